// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the cache/memory side of the CPU.
//   word_t          32-bit data word
//   memctl_state_t  memory controller FSM states
//   memport_t       identifies the icache or dcache port
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } memctl_state_t;

    typedef enum logic {
        MP_I,
        MP_D
    } memport_t;

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// cache_mem_ctrl_if: groups the icache, dcache and RAM signals that meet at
// the memory controller.
//   icache : iREN, iaddr -> ; <- iwait, iload
//   dcache : dREN, dWEN, daddr, dstore -> ; <- dwait, dload
//   RAM    : <- ram_ren, ram_wen, ram_addr, ram_store ; ram_load ->
// Modports:
//   slave  - the memory controller
//   master - caches and RAM model together (the controller's environment)
interface cache_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    import cpu_types_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    word_t             iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    word_t             dstore;
    logic              dwait;
    word_t             dload;

    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    word_t             ram_store;
    word_t             ram_load;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load,
        output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load,
        input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
    );

endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: combinational two-way round-robin choice between the
// icache and dcache ports.
//   req_i       icache is requesting
//   req_d       dcache is requesting
//   last_served port that completed most recently (held by the parent)
//   grant       winning port; only meaningful when req_i or req_d is set
module mem_rr_arbiter
    import cpu_types_pkg::*;
(
    input  logic     req_i,
    input  logic     req_d,
    input  memport_t last_served,
    output memport_t grant
);

    always_comb begin
        grant = MP_I;
        if (req_i && req_d) begin
            grant = (last_served == MP_I) ? MP_D : MP_I;
        end else if (req_d) begin
            grant = MP_D;
        end
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: memory-side responder for the icache and dcache. Serves one
// transfer at a time on a synchronous-read word RAM with a fixed latency of
// LAT cycles from grant to completion.
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   bus  cache/RAM signals (slave modport of cache_mem_ctrl_if)
// The wait outputs drop for exactly the completion cycle; load data is valid
// in that cycle only. Writes reach the RAM only in the completion cycle, so an
// abandoned or reset transfer never commits.
module cache_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int LAT    = 2,
    parameter int ADDR_W = 32
) (
    input logic             CLK,
    input logic             RST,
    cache_mem_ctrl_if.slave bus
);

    localparam int                CNT_W   = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LAT);

    memctl_state_t     state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    memport_t          last_served, last_served_n;
    logic [ADDR_W-1:0] lat_addr, lat_addr_n;
    word_t             lat_store, lat_store_n;
    logic              lat_write, lat_write_n;

    logic              req_d;
    logic              busy_active;
    memport_t          grant;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    // dREN+dWEN together is illegal on the bus; dWEN takes precedence.
    assign req_d = bus.dREN | bus.dWEN;

    mem_rr_arbiter u_arb (
        .req_i       (bus.iREN),
        .req_d       (req_d),
        .last_served (last_served),
        .grant       (grant)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            last_served <= MP_I;
            lat_addr    <= '0;
            lat_store   <= '0;
            lat_write   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_served <= last_served_n;
            lat_addr    <= lat_addr_n;
            lat_store   <= lat_store_n;
            lat_write   <= lat_write_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        last_served_n = last_served;
        lat_addr_n    = lat_addr;
        lat_store_n   = lat_store;
        lat_write_n   = lat_write;
        busy_active   = 1'b0;

        bus.iwait     = 1'b1;
        bus.dwait     = 1'b1;
        bus.iload     = '0;
        bus.dload     = '0;
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;

        case (state)
            IDLE: begin
                if (bus.iREN || req_d) begin
                    if (grant == MP_I) begin
                        state_n     = BUSY_I;
                        lat_addr_n  = word_addr(bus.iaddr);
                        lat_store_n = '0;
                        lat_write_n = 1'b0;
                    end else begin
                        state_n     = BUSY_D;
                        lat_addr_n  = word_addr(bus.daddr);
                        lat_store_n = bus.dstore;
                        lat_write_n = bus.dWEN;
                    end
                    cnt_n = CNT_W'(1);
                    // Reads start in the grant cycle so the registered RAM
                    // data lines up with completion at grant + LAT.
                    if (!lat_write_n) begin
                        bus.ram_ren  = 1'b1;
                        bus.ram_addr = lat_addr_n;
                    end
                end
            end

            BUSY_I, BUSY_D: begin
                busy_active = (state == BUSY_I) ? bus.iREN : req_d;
                if (!busy_active) begin
                    // Requester gave up: drop the transfer silently.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n       = IDLE;
                    cnt_n         = '0;
                    last_served_n = (state == BUSY_I) ? MP_I : MP_D;
                    if (state == BUSY_I) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ram_load;
                    end else begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.ram_load;
                    end
                    if (lat_write) begin
                        bus.ram_wen   = 1'b1;
                        bus.ram_addr  = lat_addr;
                        bus.ram_store = lat_store;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (!lat_write) begin
                        bus.ram_ren  = 1'b1;
                        bus.ram_addr = lat_addr;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Outputs read as their reset values while RST is held, even though
        // the registered state only clears at the next edge.
        if (RST) begin
            bus.iwait     = 1'b1;
            bus.dwait     = 1'b1;
            bus.iload     = '0;
            bus.dload     = '0;
            bus.ram_ren   = 1'b0;
            bus.ram_wen   = 1'b0;
            bus.ram_addr  = '0;
            bus.ram_store = '0;
        end
    end

endmodule
